i2c_slave_core: RTL and testbench
=================================

I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, the 7-bit address this slave responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the flip-flop depth of the SCL/SDA input synchronizers (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port scl_i  input  1  bus SCL level, asynchronous to clk.
REQ-006 SHALL have port sda_i  input  1  bus SDA level, asynchronous to clk.
REQ-007 SHALL have port sda_o  output  1  SDA drive: 0 pulls the bus low, 1 releases it (open-drain semantics).
REQ-008 SHALL have port wr_valid  output  1  one-cycle pulse: a received write byte is present on wr_data.
REQ-009 SHALL have port wr_data  output  8  last received write byte; held until the next wr_valid.
REQ-010 SHALL have port rd_req  output  1  one-cycle pulse requesting the next read byte.
REQ-011 SHALL have port rd_data  input  8  read byte; sampled exactly 1 clk after rd_req.
REQ-012 SHALL have port busy  output  1  high from a matched address until STOP or a new START.

Function
REQ-013 SHALL pass scl_i and sda_i through SYNC_STAGES flip-flops, then one further register for edge detection. All edge events SHALL use these synchronized signals only; clk SHALL be at least 8x the SCL rate.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; neither SHALL count as a data bit.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and IGNORE.
REQ-016 SHALL go to ADDR on START from any state, which includes repeated START; the bit counter SHALL clear and sda_o SHALL release.
REQ-017 SHALL go to IDLE on STOP from any state, release sda_o and drop busy; the STOP SHALL not generate wr_valid or rd_req.
REQ-018 SHALL sample SDA into the shift register, MSB first, on each synchronized SCL rising edge while in ADDR, WR_DATA or RD_ACK.
REQ-019 SHALL compare the address after the 8th SCL rise in ADDR: 7 address bits followed by the R/Wn bit.
- On match, the slave SHALL drive sda_o=0 at the next SCL fall (state ADDR_ACK) and assert busy.
- On mismatch, the slave SHALL go to IGNORE with sda_o=1 until START or STOP.
REQ-020 SHALL, on the SCL fall that ends ADDR_ACK (9th fall), release sda_o and go to WR_DATA when R/Wn=0. When R/Wn=1 it SHALL pulse rd_req and go to RD_DATA.
REQ-021 SHALL in WR_DATA, after the 8th SCL rise, load wr_data, pulse wr_valid for 1 clk and drive ACK (sda_o=0) from the next SCL fall to the following SCL fall (WR_ACK), then return to WR_DATA.
REQ-022 SHALL latch rd_data 1 clk after rd_req, then drive the MSB on sda_o. Each following bit SHALL be driven on each following SCL fall, bits 7..0. The bus setup is guaranteed because rd_req fires at an SCL fall and SCL low lasts more than 3 clk.
REQ-023 SHALL release sda_o at the SCL fall after bit 0 and sample the master ACK at the next SCL rise (RD_ACK).
- ACK=0: at the next SCL fall, pulse rd_req and return to RD_DATA.
- NACK=1: go to IGNORE.
REQ-024 SHALL change sda_o only 1 to 3 clk after a synchronized SCL fall, or on START/STOP/reset, and never while synchronized SCL is high.
REQ-025 SHALL never assert wr_valid and rd_req in the same cycle; each pulse SHALL be exactly 1 clk wide.
REQ-026 SHALL treat a START or STOP that arrives mid-byte as an abort: the partial byte is discarded and no wr_valid is issued.

Reset
REQ-027 SHALL, with rst_n low, asynchronously force: state IDLE, sda_o=1, wr_valid=0, rd_req=0, busy=0, wr_data=8'h00, shift register and bit counter 0.
REQ-028 SHALL preset synchronizer and edge registers to 1 (idle bus) so that reset release cannot produce a false START or STOP.
REQ-029 SHALL, if reset occurs mid-transfer, stay in IDLE after release until a new START, ignoring the remaining bits.

Verification
REQ-030 Write 1 byte 8'hA5 to 7'h42, then STOP -> sda_o=0 during both ACK bits; exactly one wr_valid with wr_data=8'hA5; busy low after STOP.
REQ-031 Write 4 bytes 8'h01,8'h02,8'h03,8'h04 -> four wr_valid pulses in order with matching data; 5 ACKs total.
REQ-032 Read 2 bytes from 7'h42, rd_data supplying 8'h3C then 8'hC3 -> master captures 8'h3C, 8'hC3; two rd_req pulses; sda_o=1 after STOP.
REQ-033 Write to 7'h21 -> sda_o stays 1 throughout; no wr_valid; busy stays 0.
REQ-034 Repeated START after the address ACK of a write, then a read of 1 byte -> no wr_valid; one rd_req; correct byte returned.
REQ-035 Assert rst_n low during the 4th data bit of a write, release, then write 8'h5A -> first byte lost; one wr_valid with 8'h5A.

Source files
------------

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C slave that ACKs its address, streams write bytes out and read bytes in
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, wr_data_q, wr_data_d;
  logic sda_o_q, sda_o_d, wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d, rw_q, rw_d;
  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;
  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};
  assign sda_o     = sda_o_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;
  // Bus synchronizers and edge registers, preset high so reset release looks like an idle bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end
  // Protocol state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      wr_data_q  <= '0;
      sda_o_q    <= 1'b1;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_data_q  <= wr_data_d;
      sda_o_q    <= sda_o_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end
  // Next state: START/STOP override everything, otherwise bit-level progress on SCL edges
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wr_data_d  = wr_data_q;
    sda_o_d    = sda_o_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_o_d = 1'b1;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_o_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (shift_in[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = shift_in[0];
            end else state_d = IGNORE;
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            sda_o_d = 1'b0;
            cnt_d   = 4'd1;
          end else begin
            sda_o_d  = 1'b1;
            cnt_d    = '0;
            rd_req_d = (state_q == ADDR_ACK) && rw_q;
            state_d  = ((state_q == ADDR_ACK) && rw_q) ? RD_DATA : WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d      = '0;
            wr_data_d  = shift_in;
            wr_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
        RD_DATA: if (rd_req_q) begin
          shift_d = rd_data;
          sda_o_d = rd_data[7];
          cnt_d   = '0;
        end else if (scl_rise) cnt_d = cnt_q + 4'd1;
        else if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_o_d = 1'b1;
            cnt_d   = '0;
            state_d = RD_ACK;
          end else begin
            shift_d = shift_q << 1;
            sda_o_d = shift_q[6];
          end
        end
        RD_ACK: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = 4'd1;
        end else if (scl_fall && cnt_q == 4'd1) begin
          cnt_d    = '0;
          rd_req_d = ~shift_q[0];
          state_d  = shift_q[0] ? IGNORE : RD_DATA;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: bus-level master driving the slave, checked against a transaction-level model
module tb_i2c_slave_core;
  localparam logic [6:0] SLV = 7'h42;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic sda_o, wr_valid, rd_req, busy, sda_bus;
  logic [7:0] wr_data;
  logic [7:0] dat[4];
  logic [7:0] wr_obs[$], exp_wr[$];
  int rdreq_obs = 0, exp_rdreq = 0, n_checks = 0, n_fails = 0;
  logic sda_prev = 1'b1, wr_valid_prev = 1'b0, rd_req_prev = 1'b0;
  assign sda_bus = sda_m & sda_o;
  i2c_slave_core #(.SLAVE_ADDR(SLV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Bus monitor: collects pulses and checks pulse rules and SDA timing
  always @(posedge clk) begin
    #1;
    if (wr_valid) wr_obs.push_back(wr_data);
    if (rd_req) rdreq_obs <= rdreq_obs + 1;
    if (wr_valid || rd_req) chk("pulse_exclusive", 32'(wr_valid & rd_req), 32'(0));
    if (wr_valid) chk("wr_valid_width", 32'(wr_valid_prev), 32'(0));
    if (rd_req) chk("rd_req_width", 32'(rd_req_prev), 32'(0));
    if (rst_n && sda_o !== sda_prev) chk("sda_change_scl_low", 32'(scl_m), 32'(0));
    sda_prev      <= sda_o;
    wr_valid_prev <= wr_valid;
    rd_req_prev   <= rd_req;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c();
    sda_m = 1'b1; tick(8); scl_m = 1'b1; tick(8); sda_m = 1'b0; tick(8); scl_m = 1'b0; tick(8);
  endtask
  task automatic stop_c();
    sda_m = 1'b0; tick(8); scl_m = 1'b1; tick(8); sda_m = 1'b1; tick(16);
  endtask
  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b; tick(8); scl_m = 1'b1; tick(8); s = sda_bus; tick(8); scl_m = 1'b0; tick(8);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask
  task automatic check_end();
    chk("busy_after_stop", 32'(busy), 32'(0));
    chk("sda_released", 32'(sda_o), 32'(1));
    chk("wr_count", 32'(wr_obs.size()), 32'(exp_wr.size()));
    while (wr_obs.size() > 0 && exp_wr.size() > 0) chk("wr_data", 32'(wr_obs.pop_front()), 32'(exp_wr.pop_front()));
    wr_obs.delete();
    exp_wr.delete();
    chk("rd_req_count", 32'(rdreq_obs), 32'(exp_rdreq));
  endtask
  // One complete transaction; the model predicts ACKs, written bytes, read bytes and rd_req count
  task automatic do_xact(input logic [6:0] a, input logic rw, input int n);
    logic ack, s;
    logic [7:0] b;
    logic match;
    match = (a == SLV);
    if (rw) rd_data = dat[0];
    start_c();
    send_byte({a, rw}, ack);
    chk("addr_ack", 32'(ack), 32'(!match));
    chk("busy_in_xfer", 32'(busy), 32'(match));
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        send_byte(dat[k], ack);
        chk("data_ack", 32'(ack), 32'(!match));
        if (match) exp_wr.push_back(dat[k]);
      end else begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          bit_cycle(1'b1, s);
          b = {b[6:0], s};
        end
        if (k + 1 < n) rd_data = dat[k + 1];
        bit_cycle(k == n - 1, s);
        chk("rd_byte", 32'(b), match ? 32'(dat[k]) : 32'hFF);
        if (match) exp_rdreq++;
      end
    end
    stop_c();
    check_end();
  endtask
  initial begin
    logic ack, s;
    logic [7:0] b;
    logic [6:0] a;
    tick(4);
    chk("rst_sda_o", 32'(sda_o), 32'(1));
    chk("rst_wr_valid", 32'(wr_valid), 32'(0));
    chk("rst_rd_req", 32'(rd_req), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    rst_n = 1'b1;
    tick(8);
    chk("post_rst_idle_busy", 32'(busy), 32'(0));
    dat[0] = 8'hA5;
    do_xact(SLV, 1'b0, 1);
    dat = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_xact(SLV, 1'b0, 4);
    dat[0] = 8'h3C; dat[1] = 8'hC3;
    do_xact(SLV, 1'b1, 2);
    dat[0] = 8'($urandom);
    do_xact(7'h21, 1'b0, 1);
    start_c();
    send_byte({SLV, 1'b0}, ack);
    chk("rs_addr_ack", 32'(ack), 32'(0));
    dat[0] = 8'($urandom);
    do_xact(SLV, 1'b1, 1);
    b = 8'($urandom);
    start_c();
    send_byte({SLV, 1'b0}, ack);
    chk("rst_xfer_addr_ack", 32'(ack), 32'(0));
    for (int i = 7; i >= 5; i--) bit_cycle(b[i], s);
    sda_m = b[4]; tick(4);
    rst_n = 1'b0; tick(2);
    chk("midrst_wr_data", 32'(wr_data), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1; tick(2);
    scl_m = 1'b1; tick(16); scl_m = 1'b0; tick(8);
    for (int i = 3; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
    chk("ack_after_reset", 32'(ack), 32'(1));
    stop_c();
    check_end();
    dat[0] = 8'h5A;
    do_xact(SLV, 1'b0, 1);
    for (int t = 0; t < 12; t++) begin
      a = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom_range(0, 127));
      for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
      do_xact(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
